fp32_norm_round: RTL and testbench

- Stage directly downstream of the 48-bit leading-zero detector in the FP32 multiply datapath of each systolic PE.
- Consumes the raw 24x24 mantissa product, the detector's shift count and the pre-adjusted exponent.
- Normalises, rounds round-to-nearest-even, handles overflow/underflow and packs an IEEE-754 single.
- Two-stage pipeline with valid/ready backpressure.

---
 rtl/fp32_pkg.sv | 20 ++
 rtl/fp32_round_pack.sv | 63 ++++++
 rtl/fp32_norm_round.sv | 98 +++++++++
 tb/tb_fp32_norm_round.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the stage-1 payload of the multiply normalise/round path.
package fp32_pkg;

  localparam int EXP     = 8;
  localparam int MAN     = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // frac holds the normalised product below the hidden bit (hidden bit sits at bit 47).
  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [46:0] frac;
  } s1_payload_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even, overflow/underflow detection and FP32 packing.
module fp32_round_pack
  import fp32_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic             sign,
  input  logic             nan,
  input  logic             inf,
  input  logic             zero,
  input  logic [46:0]      frac,
  input  logic [EXP_W-1:0] exp_in,
  output logic [31:0]      result,
  output logic             ovf,
  output logic             unf,
  output logic             inexact
);

  logic [MAN-1:0]   man;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [MAN:0]     man_rnd;
  logic [EXP_W-1:0] exp_f;
  logic             exp_hi;
  logic             exp_lo;

  always_comb begin
    man      = frac[46:24];
    guard    = frac[23];
    sticky   = |frac[22:0];
    round_up = guard & (sticky | man[0]);
    man_rnd  = {1'b0, man} + {{MAN{1'b0}}, round_up};
    // A carry out leaves the low 23 bits at zero, which is exactly the renormalised mantissa.
    exp_f    = exp_in + {{(EXP_W-1){1'b0}}, man_rnd[MAN]};
    exp_hi   = !exp_f[EXP_W-1] && (exp_f >= EXP_W'(EXP_MAX));
    exp_lo   = exp_f[EXP_W-1] || (exp_f == '0);

    result  = '0;
    ovf     = 1'b0;
    unf     = 1'b0;
    inexact = 1'b0;
    if (nan) begin
      result = QNAN;
    end else if (inf) begin
      result = {sign, {EXP{1'b1}}, {MAN{1'b0}}};
    end else if (zero) begin
      result = {sign, {(EXP+MAN){1'b0}}};
    end else if (exp_hi) begin
      result  = {sign, {EXP{1'b1}}, {MAN{1'b0}}};
      ovf     = 1'b1;
      inexact = 1'b1;
    end else if (exp_lo) begin
      result  = {sign, {(EXP+MAN){1'b0}}};
      unf     = 1'b1;
      inexact = 1'b1;
    end else begin
      result  = {sign, exp_f[EXP-1:0], man_rnd[MAN-1:0]};
      inexact = guard | sticky;
    end
  end

endmodule

// File: rtl/fp32_norm_round.sv
// Two-stage FP32 multiply back end: normalise by the LZ count, then round and pack,
// with valid/ready backpressure at full throughput.
module fp32_norm_round
  import fp32_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int PROD_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [5:0]        in_lz,
  input  logic              in_nan,
  input  logic              in_inf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_inexact
);

  logic              s1_en;
  logic              s2_en;
  logic              s1_valid;
  s1_payload_t       s1_q;
  logic [EXP_W-1:0]  s1_exp;
  logic [PROD_W-1:0] shifted;
  logic [EXP_W-1:0]  exp1;

  logic [31:0] rp_result;
  logic        rp_ovf;
  logic        rp_unf;
  logic        rp_inexact;

  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;

  always_comb begin
    shifted = in_prod << (in_lz - 6'd1);
    exp1    = in_exp + EXP_W'(2) - EXP_W'(in_lz);
  end

  fp32_round_pack #(
    .EXP_W (EXP_W)
  ) u_round_pack (
    .sign    (s1_q.sign),
    .nan     (s1_q.nan),
    .inf     (s1_q.inf),
    .zero    (s1_q.zero),
    .frac    (s1_q.frac),
    .exp_in  (s1_exp),
    .result  (rp_result),
    .ovf     (rp_ovf),
    .unf     (rp_unf),
    .inexact (rp_inexact)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      s1_exp      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_q.sign <= in_sign;
          s1_q.nan  <= in_nan;
          s1_q.inf  <= in_inf;
          s1_q.zero <= (in_prod == '0);
          s1_q.frac <= shifted[46:0];
          s1_exp    <= exp1;
        end
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result  <= rp_result;
          out_ovf     <= rp_ovf;
          out_unf     <= rp_unf;
          out_inexact <= rp_inexact;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_norm_round.sv
// Self-checking bench for fp32_norm_round: directed vectors plus a value-level
// reference model scoreboarding every output transfer.
module tb_fp32_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [5:0]  in_lz;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] exp_q[$];
  logic        held_v = 1'b0;
  logic [35:0] held;

  always #5 clk = ~clk;

  fp32_norm_round #(
    .EXP_W  (10),
    .PROD_W (48)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_prod     (in_prod),
    .in_lz       (in_lz),
    .in_nan      (in_nan),
    .in_inf      (in_inf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Value-level model: locate the product MSB, keep 24 significant bits, round the
  // discarded remainder against one half ulp, then classify the resulting exponent.
  function automatic logic [34:0] model(input bit s, input int e, input logic [47:0] p,
                                        input bit nan, input bit inf);
    logic [63:0] pp, mant, rem, half;
    int msb, sh, ex;
    bit up;
    if (nan) return {32'h7FC0_0000, 3'b000};
    if (inf) return {s, 8'hFF, 23'd0, 3'b000};
    if (p == 48'd0) return {s, 31'd0, 3'b000};
    pp  = {16'd0, p};
    msb = 0;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    ex = e + msb - 46;
    if (msb >= 23) begin
      sh   = msb - 23;
      mant = pp >> sh;
      rem  = pp & ((64'd1 << sh) - 64'd1);
      half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
    end else begin
      mant = pp << (23 - msb);
      rem  = 64'd0;
      half = 64'd0;
    end
    up = (rem != 64'd0) && ((rem > half) || (rem == half && mant[0]));
    if (up) mant = mant + 64'd1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      ex++;
    end
    if (ex >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    if (ex <= 0) return {s, 31'd0, 3'b011};
    return {s, ex[7:0], mant[22:0], 2'b00, rem != 64'd0};
  endfunction

  function automatic logic [5:0] lz_of(input logic [47:0] p);
    int msb;
    msb = 47;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    return 6'(48 - msb);
  endfunction

  // Monitor at the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("stall_hold", {out_valid, out_result, out_ovf, out_unf, out_inexact}, held);
      check("in_ready", {35'd0, in_ready}, {35'd0, !(exp_q.size() == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected no output", out_result);
        end else begin
          check("result", {1'b0, out_result, out_ovf, out_unf, out_inexact}, {1'b0, exp_q.pop_front()});
        end
      end
      held_v = out_valid && !out_ready;
      held   = {out_valid, out_result, out_ovf, out_unf, out_inexact};
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign, int'($signed(in_exp)), in_prod, in_nan, in_inf));
    end
  end

  task automatic send(input bit s, input int e, input logic [47:0] p, input logic [5:0] lz,
                      input bit nan, input bit inf);
    int t;
    in_sign  = s;
    in_exp   = e[9:0];
    in_prod  = p;
    in_lz    = lz;
    in_nan   = nan;
    in_inf   = inf;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input bit s, input int e, input logic [47:0] p,
                          input logic [5:0] lz, input bit nan, input bit inf, input logic [34:0] lit);
    check({name, "_model"}, {1'b0, model(s, e, p, nan, inf)}, {1'b0, lit});
    send(s, e, p, lz, nan, inf);
    check({name, "_lat1"}, {35'd0, out_valid}, 36'd0);
    @(posedge clk);
    #1;
    check({name, "_lat2"}, {out_valid, out_result, out_ovf, out_unf, out_inexact}, {1'b1, lit});
  endtask

  logic [47:0] sp[8] = '{48'h4000_0000_0000, 48'h9000_0000_0000, 48'h4000_00C0_0000,
                         48'h7FFF_FFC0_0000, 48'h0000_0123_4567, 48'hABCD_EF12_3456,
                         48'h5555_5555_5555, 48'h0000_0000_0001};
  int          se[8] = '{127, 100, 130, 60, 150, 3, -20, 200};

  initial begin
    logic [3:0] pat;
    int t;
    pat       = 4'b1001;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_prod   = '0;
    in_lz     = '0;
    in_nan    = 1'b0;
    in_inf    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out", {out_valid, out_result, out_ovf, out_unf, out_inexact}, 36'd0);
    check("reset_in_ready", {35'd0, in_ready}, 36'd1);

    directed("one",     0, 127, 48'h4000_0000_0000, 6'd2, 0, 0, {32'h3F80_0000, 3'b000});
    directed("onep5sq", 0, 127, 48'h9000_0000_0000, 6'd1, 0, 0, {32'h4010_0000, 3'b000});
    directed("tie_even",0, 127, 48'h4000_0040_0000, 6'd2, 0, 0, {32'h3F80_0000, 3'b001});
    directed("tie_odd", 0, 127, 48'h4000_00C0_0000, 6'd2, 0, 0, {32'h3F80_0002, 3'b001});
    directed("carry",   0, 127, 48'h7FFF_FFC0_0000, 6'd2, 0, 0, {32'h4000_0000, 3'b001});
    directed("ovf",     0, 254, 48'h8000_0000_0000, 6'd1, 0, 0, {32'h7F80_0000, 3'b101});
    directed("unf",     0, -1,  48'h4000_0000_0000, 6'd2, 0, 0, {32'h0000_0000, 3'b011});
    directed("nan",     1, 127, 48'h4000_0000_0000, 6'd2, 1, 0, {32'h7FC0_0000, 3'b000});
    directed("inf",     1, 127, 48'h4000_0000_0000, 6'd2, 0, 1, {32'hFF80_0000, 3'b000});
    directed("zero",    1, 127, 48'h0000_0000_0000, 6'd0, 0, 0, {32'h8000_0000, 3'b000});

    // Backpressured stream; ordering and in_ready are policed by the monitor.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i[0], se[i], sp[i], lz_of(sp[i]), 0, 0);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = pat[c % 4];
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    check("stream_drained", {4'd0, 32'(exp_q.size())}, 36'd0);

    // Reset with two beats in flight: both must vanish.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 127, 48'h9000_0000_0000, 6'd1, 0, 0);
    send(0, 130, 48'h4000_0000_0000, 6'd2, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", {35'd0, out_valid}, 36'd0);
    check("midrst_in_ready", {35'd0, in_ready}, 36'd1);
    out_ready = 1'b1;
    directed("post_rst", 1, 128, 48'h9000_0000_0000, 6'd1, 0, 0, {32'hC090_0000, 3'b000});
    @(posedge clk);
    #1;
    check("post_rst_alone", {35'd0, out_valid}, 36'd0);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", {4'd0, 32'(exp_q.size())}, 36'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
